// File: rtl/fetch_top.sv
// fetch_top -- instruction fetch stage of the five-stage pipeline.
//
// Owns the PC, issues requests to instruction memory over a req/ready
// handshake and presents {out_pc, instruction, valid} registers to decode.
// Jumps from decode and taken branches from M redirect the PC. A redirect
// while a request is in flight marks that response as wrong-path so that it
// is dropped when it returns.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   stall               decode cannot accept; delivered outputs hold
//   is_jump, jump_addr  jump from decode (ignored while stalled)
//   branch, branch_addr taken branch from M (honoured even while stalled)
//   imem_req/imem_addr  memory request; address is the PC register
//   imem_ready/data     memory response for the current request
//   out_pc, instruction, valid  registered outputs to decode
module fetch_top #(
  parameter int          ADDR_SIZE  = 32,
  parameter int          INSTR_SIZE = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  is_jump,
  input  logic [ADDR_SIZE-1:0]  jump_addr,
  input  logic                  branch,
  input  logic [ADDR_SIZE-1:0]  branch_addr,
  output logic                  imem_req,
  output logic [ADDR_SIZE-1:0]  imem_addr,
  input  logic                  imem_ready,
  input  logic [INSTR_SIZE-1:0] imem_data,
  output logic [ADDR_SIZE-1:0]  out_pc,
  output logic [INSTR_SIZE-1:0] instruction,
  output logic                  valid
);

  // BUSY: a request is (or is about to be) outstanding.
  // HOLD: a fetched word is parked because decode was stalled.
  typedef enum logic {
    BUSY = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [ADDR_SIZE-1:0] PC_STEP = ADDR_SIZE'(4);

  state_t                  state_q,  state_d;
  logic [ADDR_SIZE-1:0]    pc_q,     pc_d;
  logic                    squash_q, squash_d;
  logic [INSTR_SIZE-1:0]   hold_q,   hold_d;
  logic [ADDR_SIZE-1:0]    out_pc_q, out_pc_d;
  logic [INSTR_SIZE-1:0]   instr_q,  instr_d;
  logic                    valid_q,  valid_d;

  logic                    redirect;
  logic [ADDR_SIZE-1:0]    target;

  // Decode keeps presenting a jump while stalled, so only take it when the
  // pipeline moves. A branch from M must be taken immediately.
  assign redirect = branch | (is_jump & ~stall);
  assign target   = branch ? branch_addr : jump_addr;

  assign imem_req    = (state_q == BUSY);
  assign imem_addr   = pc_q;
  assign out_pc      = out_pc_q;
  assign instruction = instr_q;
  assign valid       = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BUSY;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      hold_q   <= NOP_INSTR;
      out_pc_q <= '0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      hold_q   <= hold_d;
      out_pc_q <= out_pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    hold_d   = hold_q;
    out_pc_d = out_pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;

    if (redirect) begin
      pc_d     = target;
      valid_d  = 1'b0;
      instr_d  = NOP_INSTR;
      hold_d   = NOP_INSTR;
      state_d  = BUSY;
      // Only a request that has not yet completed leaves a stale response
      // behind; one completing this cycle is simply ignored.
      squash_d = (state_q == BUSY) && !imem_ready;
    end else begin
      unique case (state_q)
        BUSY: begin
          if (imem_ready && squash_q) begin
            // Wrong-path response returning: drop it.
            squash_d = 1'b0;
            if (!stall) begin
              valid_d = 1'b0;
              instr_d = NOP_INSTR;
            end
          end else if (imem_ready) begin
            if (!stall) begin
              out_pc_d = pc_q;
              instr_d  = imem_data;
              valid_d  = 1'b1;
              pc_d     = pc_q + PC_STEP;
            end else begin
              hold_d  = imem_data;
              state_d = HOLD;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_pc_d = pc_q;
            instr_d  = hold_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + PC_STEP;
            state_d  = BUSY;
          end
        end
        default: state_d = BUSY;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_top.sv
module tb_fetch_top;

  localparam logic [31:0] RST_PC  = 32'h0000_1000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] KEY     = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        is_jump = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        branch = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] out_pc;
  logic [31:0] instruction;
  logic        valid;

  fetch_top #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .is_jump(is_jump), .jump_addr(jump_addr),
    .branch(branch), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .out_pc(out_pc), .instruction(instruction), .valid(valid)
  );

  // Second instance: wrap-around of the PC, zero-wait memory, never stalled.
  logic        w_req;
  logic [31:0] w_addr, w_data, w_out_pc, w_instr;
  logic        w_valid;
  assign w_data = w_addr ^ KEY;

  fetch_top #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .reset(reset), .stall(1'b0),
    .is_jump(1'b0), .jump_addr(32'h0),
    .branch(1'b0), .branch_addr(32'h0),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_data(w_data),
    .out_pc(w_out_pc), .instruction(w_instr), .valid(w_valid)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Instruction memory: latches the address on the first request cycle and
  // returns addr ^ KEY for that address whenever it answers.
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;

  // Reference model: the fetch stage seen as "a PC, at most one fetched word
  // waiting for decode, and whether the response in flight is wrong-path".
  logic [31:0] m_pc = RST_PC, m_buf = '0, m_out_pc = '0, m_instr = NOP;
  logic        m_have = 1'b0, m_wrong = 1'b0, m_valid = 1'b0;

  task automatic model_step();
    logic        req, got;
    logic [31:0] word;
    if (reset) begin
      m_pc = RST_PC; m_have = 1'b0; m_wrong = 1'b0;
      m_out_pc = '0; m_instr = NOP; m_valid = 1'b0;
    end else begin
      req = !m_have;
      if (branch || (is_jump && !stall)) begin
        m_wrong = req && !imem_ready;
        m_have  = 1'b0;
        m_pc    = branch ? branch_addr : jump_addr;
        m_valid = 1'b0;
        m_instr = NOP;
      end else begin
        got  = m_have || (req && imem_ready && !m_wrong);
        word = m_have ? m_buf : imem_data;
        if (req && imem_ready) m_wrong = 1'b0;
        if (!stall) begin
          if (got) begin
            m_out_pc = m_pc; m_instr = word; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_have = 1'b0;
          end else begin
            m_valid = 1'b0; m_instr = NOP;
          end
        end else if (got && !m_have) begin
          m_have = 1'b1; m_buf = word;
        end
      end
    end
  endtask

  // One clock: drive inputs at the falling edge, step the model, take the
  // rising edge and leave time 1 unit after it for sampling.
  task automatic cycle(input logic rst, input logic st, input logic jmp, input logic [31:0] ja,
                       input logic br, input logic [31:0] ba, input logic want_rdy);
    @(negedge clk);
    reset = rst; stall = st; is_jump = jmp; jump_addr = ja;
    branch = br; branch_addr = ba;
    if (!rst && imem_req && !mem_busy) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
    end
    imem_ready = want_rdy && mem_busy && !rst;
    imem_data  = mem_busy ? (mem_addr ^ KEY) : $urandom();
    model_step();
    @(posedge clk);
    if (rst || imem_ready) mem_busy = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        st, jmp;
    logic [31:0] ja;
    logic        br;
    logic [31:0] ba;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr, e_pc, e_instr;
    logic        e_valid;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic jmp, input logic [31:0] ja,
                              input logic br, input logic [31:0] ba, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic e_valid);
    vec_t v;
    v.st = st; v.jmp = jmp; v.ja = ja; v.br = br; v.ba = ba; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    // Sequential zero-wait, wait states + stall into HOLD, jump with squash,
    // stalled jump ignored, branch from HOLD, branch+jump priority with
    // squash, redirect coinciding with ready.
    tbl[0]  = mk(0,0,0,      0,0,      1, 1,32'h1004,32'h1000,32'hA5A5_1000,1);
    tbl[1]  = mk(0,0,0,      0,0,      1, 1,32'h1008,32'h1004,32'hA5A5_1004,1);
    tbl[2]  = mk(0,0,0,      0,0,      1, 1,32'h100C,32'h1008,32'hA5A5_1008,1);
    tbl[3]  = mk(0,0,0,      0,0,      0, 1,32'h100C,32'h1008,NOP,          0);
    tbl[4]  = mk(0,0,0,      0,0,      0, 1,32'h100C,32'h1008,NOP,          0);
    tbl[5]  = mk(1,0,0,      0,0,      1, 0,32'h100C,32'h1008,NOP,          0);
    tbl[6]  = mk(1,0,0,      0,0,      0, 0,32'h100C,32'h1008,NOP,          0);
    tbl[7]  = mk(0,0,0,      0,0,      0, 1,32'h1010,32'h100C,32'hA5A5_100C,1);
    tbl[8]  = mk(0,1,32'h2000,0,0,     0, 1,32'h2000,32'h100C,NOP,          0);
    tbl[9]  = mk(0,0,0,      0,0,      1, 1,32'h2000,32'h100C,NOP,          0);
    tbl[10] = mk(0,0,0,      0,0,      1, 1,32'h2004,32'h2000,32'hA5A5_2000,1);
    tbl[11] = mk(1,1,32'h6000,0,0,     1, 0,32'h2004,32'h2000,32'hA5A5_2000,1);
    tbl[12] = mk(1,0,0,      1,32'h3000,0,1,32'h3000,32'h2000,NOP,          0);
    tbl[13] = mk(0,0,0,      0,0,      1, 1,32'h3004,32'h3000,32'hA5A5_3000,1);
    tbl[14] = mk(0,1,32'h5000,1,32'h4000,0,1,32'h4000,32'h3000,NOP,         0);
    tbl[15] = mk(0,0,0,      0,0,      0, 1,32'h4000,32'h3000,NOP,          0);
    tbl[16] = mk(0,0,0,      0,0,      1, 1,32'h4000,32'h3000,NOP,          0);
    tbl[17] = mk(0,0,0,      0,0,      1, 1,32'h4004,32'h4000,32'hA5A5_4000,1);
    tbl[18] = mk(0,1,32'h2000,0,0,     1, 1,32'h2000,32'h4000,NOP,          0);
    tbl[19] = mk(0,0,0,      0,0,      1, 1,32'h2004,32'h2000,32'hA5A5_2000,1);

    // Reset state.
    cycle(1,0,0,0,0,0,0);
    cycle(1,0,0,0,0,0,0);
    chk("rst_req",    imem_req,    1);
    chk("rst_addr",   imem_addr,   RST_PC);
    chk("rst_out_pc", out_pc,      0);
    chk("rst_instr",  instruction, NOP);
    chk("rst_valid",  valid,       0);
    chk("wrap_rst_addr", w_addr,   WRAP_PC);

    for (int i = 0; i < 20; i++) begin
      cycle(0, tbl[i].st, tbl[i].jmp, tbl[i].ja, tbl[i].br, tbl[i].ba, tbl[i].rdy);
      $display("vec %0d: req=%b addr=%h out_pc=%h instr=%h valid=%b",
               i, imem_req, imem_addr, out_pc, instruction, valid);
      chk($sformatf("v%0d_req", i),   imem_req,    tbl[i].e_req);
      chk($sformatf("v%0d_addr", i),  imem_addr,   tbl[i].e_addr);
      chk($sformatf("v%0d_pc", i),    out_pc,      tbl[i].e_pc);
      chk($sformatf("v%0d_instr", i), instruction, tbl[i].e_instr);
      chk($sformatf("v%0d_valid", i), valid,       tbl[i].e_valid);
      if (i == 0) begin
        chk("wrap_pc0",    w_out_pc, WRAP_PC);
        chk("wrap_instr0", w_instr,  WRAP_PC ^ KEY);
        chk("wrap_valid0", w_valid,  1);
        chk("wrap_addr1",  w_addr,   32'h0);
        chk("wrap_req",    w_req,    1);
      end
      if (i == 1) begin
        chk("wrap_pc1",    w_out_pc, 32'h0);
        chk("wrap_instr1", w_instr,  KEY);
      end
    end

    // Reset while parked in HOLD.
    cycle(0,1,0,0,0,0,1);
    $display("hold: req=%b addr=%h", imem_req, imem_addr);
    chk("hold_req", imem_req, 0);
    cycle(1,1,0,0,0,0,0);
    $display("reset in hold: req=%b addr=%h valid=%b", imem_req, imem_addr, valid);
    chk("rhold_valid", valid,       0);
    chk("rhold_instr", instruction, NOP);
    chk("rhold_addr",  imem_addr,   RST_PC);
    chk("rhold_req",   imem_req,    1);
    chk("rhold_pc",    out_pc,      0);
    cycle(0,0,0,0,0,0,1);
    $display("after reset: out_pc=%h instr=%h valid=%b", out_pc, instruction, valid);
    chk("rhold_first_pc",    out_pc,      RST_PC);
    chk("rhold_first_instr", instruction, RST_PC ^ KEY);
    chk("rhold_first_valid", valid,       1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_st, r_jmp, r_br, r_rdy;
      logic [31:0] r_ja, r_ba;
      r_rst = ($urandom_range(99) == 0);
      r_st  = ($urandom_range(99) < 30);
      r_jmp = ($urandom_range(99) < 10);
      r_br  = ($urandom_range(99) < 5);
      r_rdy = ($urandom_range(1) == 1);
      r_ja  = $urandom() & 32'hFFFF_FFFC;
      r_ba  = $urandom() & 32'hFFFF_FFFC;
      cycle(r_rst, r_st, r_jmp, r_ja, r_br, r_ba, r_rdy);
      chk($sformatf("rnd%0d_req", n),   imem_req,    !m_have);
      chk($sformatf("rnd%0d_addr", n),  imem_addr,   m_pc);
      chk($sformatf("rnd%0d_pc", n),    out_pc,      m_out_pc);
      chk($sformatf("rnd%0d_instr", n), instruction, m_instr);
      chk($sformatf("rnd%0d_valid", n), valid,       m_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
